// File: rtl/match_bind_stream.sv
// Streaming match/bind engine: a DEPTH-entry word FIFO feeding a registered
// result stage that binds words into an accumulator or XORs them against it.
module match_bind_stream #(
    parameter int W         = 8,
    parameter int DEPTH     = 4,
    parameter int MATCH_BIT = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   out_tag,
    output logic [15:0]  out_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [W-1:0]  acc;
    logic [W-1:0]  head;
    logic          push;
    logic          pop;

    // in_ready looks at registered occupancy only, so a full FIFO never
    // admits a push even when the head is leaving in the same cycle.
    assign in_ready = (count < CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (count != '0) && (!out_valid || out_ready);
    assign head     = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= 2'b00;
            out_count <= '0;
        end else if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end

            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            // The result register only loads on a pop, so it holds steady
            // under backpressure.
            if (pop) begin
                out_valid <= 1'b1;
                if (head[MATCH_BIT]) begin
                    out_data <= acc ^ head;
                    out_tag  <= 2'b10;
                end else begin
                    acc      <= head;
                    out_data <= head;
                    out_tag  <= 2'b01;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (out_valid && out_ready) begin
                out_count <= out_count + 16'd1;
            end
        end
    end

endmodule
